ws2812_multi_driver: RTL and testbench
======================================

// Module: ws2812_multi_driver
// PURPOSE
//  Drives NUM_CHANNELS independent WS2812-style LED strings in lockstep from one clock.
//  Pixel data is fetched per LED from a RAM-like port (1-cycle read latency), not a flat bus.
//  Sits between the pixel buffer (SPI-fed or pattern generator) and the LED output pins.
//  Generalises the single-string 24-bit driver: multiple channels, RGB/RGBW, timing params, auto-repeat.
// PARAMETERS
//  NUM_LEDS       20    LEDs per string (>=1)
//  NUM_CHANNELS   1     parallel strings, one output pin each (>=1)
//  BITS_PER_LED   24    24 = GRB, 32 = GRBW; sent MSB first
//  T0H            7     clk cycles high for a '0' bit (0.35us @ 20.46MHz)
//  T1H            14    clk cycles high for a '1' bit; T0H < T1H < T_BIT
//  T_BIT          26    clk cycles per bit period (1.25us)
//  T_RESET        1100  clk cycles line-low latch gap after the frame (>50us)
//  AW             $clog2(NUM_LEDS), min 1; width of pix_addr
// PORTS
//  clk          in   1                        system clock
//  reset        in   1                        asynchronous, active-high
//  start        in   1                        frame request; sampled only in IDLE
//  auto_repeat  in   1                        restart immediately after finish
//  pix_addr     out  AW                       LED index being fetched
//  pix_rd       out  1                        read strobe, one cycle per fetch
//  pix_data     in   NUM_CHANNELS*BITS_PER_LED  channel c at [c*BITS_PER_LED +: BITS_PER_LED]; valid 1 cycle after pix_rd
//  led          out  NUM_CHANNELS             serial data lines, registered
//  busy         out  1                        high from FETCH through end of LATCH
//  finish       out  1                        one-cycle pulse when frame and latch gap are complete
// BEHAVIOUR
//  Reset (async): state IDLE; led=0, busy=0, finish=0, pix_rd=0, pix_addr=0; all counters cleared.
//  States: IDLE -> FETCH -> SEND -> LATCH -> IDLE.
//  IDLE: start=1 at edge k -> FETCH in cycle k+1: pix_addr=0, pix_rd=1, busy=1.
//  FETCH: 1 cycle; next edge loads pix_data into the shift regs and enters SEND.
//   The first led rising edge is registered at edge k+2.
//  SEND: each bit is exactly T_BIT cycles; line high for T1H ('1') or T0H ('0') from bit start, then low.
//   All channels share the bit timing; each channel takes its own data bit.
//  Prefetch: in the first cycle of bit 0 of LED n (n < NUM_LEDS-1), pix_rd=1 and pix_addr=n+1.
//   Data is captured into a holding reg next cycle and loaded at the end of LED n's last bit, with no gap.
//  pix_rd is never asserted outside FETCH or prefetch cycles; pix_addr holds its last value otherwise.
//  After the last bit of LED NUM_LEDS-1 -> LATCH: led=0 for T_RESET cycles.
//  End of LATCH: finish=1 for one cycle, busy=0 that cycle, state IDLE.
//   Then, if auto_repeat=1 or start=1 in the finish cycle, the next frame starts as from edge k.
//  Finish timing: pulse exactly 1+NUM_LEDS*BITS_PER_LED*T_BIT+T_RESET cycles after the start-sampling edge.
//  start while busy: ignored, not queued.
//  Reset mid-frame: led drops to 0 immediately; no finish pulse is issued.
//  NUM_LEDS=1: no prefetch occurs; pix_addr stays 0.
// TESTING (bench params unless noted: NUM_LEDS=2, NUM_CHANNELS=2, BITS=8, T0H=2, T1H=4, T_BIT=6, T_RESET=10)
//  1 Reset then idle 50 cycles -> led=0, busy=0, pix_rd=0, finish never pulses.
//  2 RAM[0]={ch1:8'hA5,ch0:8'hFF}, RAM[1]={8'h00,8'h81}, start pulse ->
//    ch0 high widths 4,4,4,4,4,4,4,4 | 4,2,2,2,2,2,2,4;
//    ch1 high widths 4,2,4,2,2,4,2,4 | all 2; every period is 6.
//  3 Same frame -> pix_rd asserted exactly twice (addr 0, then addr 1 at LED0 bit0);
//    finish 107 cycles after the start edge; led low during the last 10 cycles.
//  4 start re-pulsed mid-frame -> no effect; exactly one finish pulse, period unchanged.
//  5 auto_repeat=1 -> back-to-back frames; consecutive finish pulses 107 cycles apart; no IDLE gap beyond the finish cycle.
//  6 Async reset asserted mid-bit (line high) -> led=0 same cycle, busy=0, no finish;
//    next start gives a clean frame matching scenario 2.

Source files
------------

// File: rtl/ws2812_multi_driver_if.sv
// Pixel-buffer read port: the driver issues address plus read strobe,
// and the buffer answers with every channel's pixel word on pix_data.
interface ws2812_multi_driver_if #(
   parameter int AW = 1,
   parameter int DW = 24
);
   logic [AW-1:0] pix_addr;
   logic          pix_rd;
   logic [DW-1:0] pix_data;

   modport master (output pix_addr, output pix_rd, input pix_data);
   modport slave  (input pix_addr, input pix_rd, output pix_data);
endinterface

// File: rtl/ws2812_multi_driver.sv
// Lockstep WS2812 driver for NUM_CHANNELS strings; pixels are fetched per LED
// from a RAM-like port and the next LED is prefetched while the current one shifts out.
module ws2812_multi_driver #(
   parameter int NUM_LEDS     = 20,
   parameter int NUM_CHANNELS = 1,
   parameter int BITS_PER_LED = 24,
   parameter int T0H          = 7,
   parameter int T1H          = 14,
   parameter int T_BIT        = 26,
   parameter int T_RESET      = 1100,
   parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      auto_repeat,
   ws2812_multi_driver_if.master     pix,
   output logic [NUM_CHANNELS-1:0]   led,
   output logic                      busy,
   output logic                      finish
);
   localparam int DW = NUM_CHANNELS * BITS_PER_LED;
   localparam int CW = $clog2(T_BIT + 1);
   localparam int BW = $clog2(BITS_PER_LED + 1);
   localparam int LW = $clog2(T_RESET + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
   localparam logic [CW-1:0] T0H_C    = CW'(T0H);
   localparam logic [CW-1:0] T1H_C    = CW'(T1H);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_LED - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(T_RESET - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cyc_q, cyc_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic [LW-1:0]           lcnt_q, lcnt_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic                    rd_q, rd_d;
   logic                    busy_q, busy_d;
   logic                    finish_q, finish_d;
   logic [NUM_CHANNELS-1:0] led_q, led_d;
   logic [DW-1:0]           shift_q, shift_d;
   logic [DW-1:0]           hold_q, hold_d;

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      bit_d    = bit_q;
      idx_d    = idx_q;
      lcnt_d   = lcnt_q;
      addr_d   = addr_q;
      rd_d     = 1'b0;
      busy_d   = busy_q;
      finish_d = 1'b0;
      led_d    = '0;
      shift_d  = shift_q;
      hold_d   = hold_q;

      // The line lags the bit counters by one cycle so every output stays a flop.
      if (state_q == SEND) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (shift_q[c*BITS_PER_LED + BITS_PER_LED - 1]) led_d[c] = (cyc_q < T1H_C);
            else                                            led_d[c] = (cyc_q < T0H_C);
         end
      end

      if (rd_q && state_q == SEND) hold_d = pix.pix_data;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               addr_d  = '0;
               rd_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         FETCH: begin
            state_d = SEND;
            busy_d  = 1'b1;
            shift_d = pix.pix_data;
            cyc_d   = '0;
            bit_d   = '0;
            idx_d   = '0;
            if (NUM_LEDS > 1) begin
               rd_d   = 1'b1;
               addr_d = AW'(1);
            end
         end
         SEND: begin
            busy_d = 1'b1;
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  if (int'(idx_q) == NUM_LEDS - 1) begin
                     state_d = LATCH;
                     lcnt_d  = '0;
                  end else begin
                     idx_d   = idx_q + AW'(1);
                     shift_d = hold_q;
                     if (int'(idx_q) + 2 < NUM_LEDS) begin
                        rd_d   = 1'b1;
                        addr_d = idx_q + AW'(2);
                     end
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
                  for (int c = 0; c < NUM_CHANNELS; c++)
                     shift_d[c*BITS_PER_LED +: BITS_PER_LED] = shift_q[c*BITS_PER_LED +: BITS_PER_LED] << 1;
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         LATCH: begin
            busy_d = 1'b1;
            if (lcnt_q == LAT_LAST) begin
               // The finish edge doubles as the start-sampling edge of the next frame.
               finish_d = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
               if (auto_repeat || start) begin
                  state_d = FETCH;
                  addr_d  = '0;
                  rd_d    = 1'b1;
               end
            end else begin
               lcnt_d = lcnt_q + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         bit_q    <= '0;
         idx_q    <= '0;
         lcnt_q   <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
         led_q    <= '0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         bit_q    <= bit_d;
         idx_q    <= idx_d;
         lcnt_q   <= lcnt_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
         led_q    <= led_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
   end

   assign pix.pix_addr = addr_q;
   assign pix.pix_rd   = rd_q;
   assign led          = led_q;
   assign busy         = busy_q;
   assign finish       = finish_q;
endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Bench for ws2812_multi_driver: 2 LEDs x 2 channels x 8 bits, short timing.
module tb_ws2812_multi_driver;
   localparam int NL = 2, NC = 2, NB = 8, T0 = 2, T1 = 4, TB = 6, TR = 10;
   localparam int FRAME = 1 + NL*NB*TB + TR;   // 107
   localparam int NREC  = 400;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic auto_repeat = 1'b0;
   logic [NC-1:0] led;
   logic busy, finish;
   logic [NC*NB-1:0] ram [NL];

   ws2812_multi_driver_if #(.AW(1), .DW(NC*NB)) pix ();

   ws2812_multi_driver #(
      .NUM_LEDS(NL), .NUM_CHANNELS(NC), .BITS_PER_LED(NB),
      .T0H(T0), .T1H(T1), .T_BIT(TB), .T_RESET(TR)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .auto_repeat(auto_repeat),
      .pix(pix), .led(led), .busy(busy), .finish(finish)
   );

   always #5 clk = ~clk;

   // Data is only driven while a read is outstanding, so mistimed captures show up.
   assign pix.pix_data = pix.pix_rd ? ram[pix.pix_addr] : '0;

   int passed = 0, total = 0;
   logic r_led0 [NREC], r_led1 [NREC], r_rd [NREC], r_fin [NREC], r_busy [NREC];
   logic r_addr [NREC];

   typedef struct packed {
      logic [15:0] r0, r1, exp0, exp1;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Serial stream of a channel: LED0 byte first, then LED1, MSB first.
   function automatic logic [15:0] stream_of(input int ch, input logic [15:0] r0, input logic [15:0] r1);
      return {r0[ch*NB +: NB], r1[ch*NB +: NB]};
   endfunction

   // Expected line level j cycles after the start-sampling edge.
   function automatic logic exp_led(input logic [15:0] s, input int j);
      int b, p;
      if (j < 2 || j >= 2 + NL*NB*TB) return 1'b0;
      b = (j - 2) / TB;
      p = (j - 2) % TB;
      return (p < (s[15-b] ? T1 : T0));
   endfunction

   task automatic record(input int n, input int extra_at, input int ar_off_at);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         r_led0[j] = led[0]; r_led1[j] = led[1];
         r_rd[j] = pix.pix_rd; r_addr[j] = pix.pix_addr;
         r_fin[j] = finish; r_busy[j] = busy;
         start = (j == extra_at);
         if (j == ar_off_at) auto_repeat = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic check_wave(input string tag, input int base, input logic [15:0] s0, input logic [15:0] s1);
      int bad0 = 0, bad1 = 0;
      for (int j = 0; j <= FRAME; j++) begin
         if (r_led0[base+j] !== exp_led(s0, j)) bad0++;
         if (r_led1[base+j] !== exp_led(s1, j)) bad1++;
      end
      chk({tag, " wave ch0 bad cycles"}, bad0, 0);
      chk({tag, " wave ch1 bad cycles"}, bad1, 0);
   endtask

   task automatic check_single(input string tag, input int n);
      int first_fin = -1, nfin = 0, nrd = 0, nbusy = 0;
      for (int j = 0; j < n; j++) begin
         if (r_fin[j] === 1'b1) begin nfin++; if (first_fin < 0) first_fin = j; end
         if (r_rd[j] === 1'b1) nrd++;
         if (j < FRAME && r_busy[j] === 1'b1) nbusy++;
      end
      chk({tag, " finish cycle"}, first_fin, FRAME);
      chk({tag, " finish count"}, nfin, 1);
      chk({tag, " pix_rd count"}, nrd, 2);
      chk({tag, " fetch addr0"}, {r_rd[0], r_addr[0]}, 2'b10);
      chk({tag, " prefetch addr1"}, {r_rd[1], r_addr[1]}, 2'b11);
      chk({tag, " busy cycles"}, nbusy, FRAME);
      chk({tag, " busy in finish cycle"}, r_busy[FRAME], 0);
   endtask

   initial begin
      int cnt;
      logic [15:0] a, b;
      int fins [$];

      vecs[0] = '{r0: 16'hA5FF, r1: 16'h0081, exp0: 16'hFF81, exp1: 16'hA500};
      vecs[1] = '{r0: 16'h0000, r1: 16'h0000, exp0: 16'h0000, exp1: 16'h0000};
      vecs[2] = '{r0: 16'hFFFF, r1: 16'hFFFF, exp0: 16'hFFFF, exp1: 16'hFFFF};
      vecs[3] = '{r0: 16'h1234, r1: 16'hC3E7, exp0: 16'h34E7, exp1: 16'h12C3};

      // Reset and idle
      repeat (3) @(negedge clk);
      chk("reset led", led, 0);
      chk("reset busy", busy, 0);
      chk("reset pix_rd", pix.pix_rd, 0);
      chk("reset finish", finish, 0);
      chk("reset pix_addr", pix.pix_addr, 0);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (led !== 2'b00 || busy !== 1'b0 || pix.pix_rd !== 1'b0 || finish !== 1'b0) cnt++;
      end
      chk("idle activity cycles", cnt, 0);

      // Directed table
      for (int v = 0; v < 4; v++) begin
         ram[0] = vecs[v].r0; ram[1] = vecs[v].r1;
         record(FRAME + 8, -1, -1);
         check_wave($sformatf("vec%0d", v), 0, vecs[v].exp0, vecs[v].exp1);
         check_single($sformatf("vec%0d", v), FRAME + 8);
      end

      // Random pixels against the model
      for (int r = 0; r < 4; r++) begin
         a = 16'($urandom); b = 16'($urandom);
         ram[0] = a; ram[1] = b;
         record(FRAME + 8, -1, -1);
         check_wave($sformatf("rand%0d", r), 0, stream_of(0, a, b), stream_of(1, a, b));
         check_single($sformatf("rand%0d", r), FRAME + 8);
      end

      // Start pulsed while busy is ignored
      ram[0] = vecs[0].r0; ram[1] = vecs[0].r1;
      record(FRAME + 8, 40, -1);
      check_wave("midstart", 0, vecs[0].exp0, vecs[0].exp1);
      check_single("midstart", FRAME + 8);

      // Auto-repeat: three back-to-back frames
      auto_repeat = 1'b1;
      record(3*FRAME + 20, -1, 2*FRAME + 50);
      for (int j = 0; j < 3*FRAME + 20; j++) if (r_fin[j] === 1'b1) fins.push_back(j);
      chk("auto finish count", fins.size(), 3);
      for (int f = 0; f < 3 && f < fins.size(); f++)
         chk($sformatf("auto finish %0d cycle", f), fins[f], (f + 1) * FRAME);
      for (int f = 0; f < 3; f++) begin
         check_wave($sformatf("auto frame%0d", f), f*FRAME, vecs[0].exp0, vecs[0].exp1);
         chk($sformatf("auto frame%0d fetch", f), {r_rd[f*FRAME], r_addr[f*FRAME]}, 2'b10);
      end
      repeat (5) @(negedge clk);

      // Async reset while the line is high
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-reset led0 high", led[0], 1);
      #2 reset = 1'b1;
      #1;
      chk("async reset led", led, 0);
      chk("async reset busy", busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < FRAME + 20; i++) begin
         @(negedge clk);
         if (finish !== 1'b0 || busy !== 1'b0) cnt++;
      end
      chk("post-reset stray activity", cnt, 0);
      record(FRAME + 8, -1, -1);
      check_wave("after reset", 0, vecs[0].exp0, vecs[0].exp1);
      check_single("after reset", FRAME + 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
